if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 108 ++++++++++
 tb/tb_if_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// if_stage : instruction fetch PC register plus the IF/ID pipeline register
// Rev 1.0  : initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic        jalr_e,
  input  logic [31:0] pc_target_e,
  input  logic [31:0] alu_result_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic [6:0]  op_d,
  output logic [2:0]  funct3_d,
  output logic        funct7b5_d,
  output logic        valid_d,
  output logic        misalign_d,
  output logic [31:0] fetch_count
);

  logic [31:0] r_pc_f;
  logic        r_misalign_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus4_d;
  logic        r_valid_d;
  logic        r_misalign_d;
  logic [31:0] r_fetch_count;

  logic [31:0] w_redirect_raw;
  logic [31:0] w_pc_plus4_f;
  logic [31:0] w_pc_next;
  logic        w_pc_en;
  logic        w_tgt_misalign;
  logic        w_unused_tgt_lsb;

  // jalr clears bit 0 and the fetch path clears bit 1, so only bits [31:2]
  // of either target survive; bit 1 is kept only to raise the misalign flag.
  always_comb begin
    w_redirect_raw = jalr_e ? alu_result_e : pc_target_e;
    w_tgt_misalign = w_redirect_raw[1];
    w_pc_plus4_f   = r_pc_f + 32'd4;
    w_pc_next      = pc_src_e ? {w_redirect_raw[31:2], 2'b00} : w_pc_plus4_f;
    w_pc_en        = !stall_f || pc_src_e;
  end

  assign w_unused_tgt_lsb = w_redirect_raw[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_f       <= RESET_PC;
      r_misalign_f <= 1'b0;
    end else if (w_pc_en) begin
      r_pc_f       <= w_pc_next;
      r_misalign_f <= pc_src_e && w_tgt_misalign;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_d     <= NOP_INSTR;
      r_pc_d        <= 32'd0;
      r_pc_plus4_d  <= 32'd0;
      r_valid_d     <= 1'b0;
      r_misalign_d  <= 1'b0;
      r_fetch_count <= 32'd0;
    end else if (flush_d) begin
      r_instr_d     <= NOP_INSTR;
      r_pc_d        <= 32'd0;
      r_pc_plus4_d  <= 32'd0;
      r_valid_d     <= 1'b0;
      r_misalign_d  <= 1'b0;
    end else if (!stall_d) begin
      r_instr_d     <= imem_rdata;
      r_pc_d        <= r_pc_f;
      r_pc_plus4_d  <= w_pc_plus4_f;
      r_valid_d     <= 1'b1;
      r_misalign_d  <= r_misalign_f;
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign imem_addr   = r_pc_f;
  assign instr_d     = r_instr_d;
  assign pc_d        = r_pc_d;
  assign pc_plus4_d  = r_pc_plus4_d;
  assign valid_d     = r_valid_d;
  assign misalign_d  = r_misalign_d;
  assign fetch_count = r_fetch_count;

  // Decode fields come straight off the register so a bubble decodes as ADDI.
  assign op_d       = r_instr_d[6:0];
  assign funct3_d   = r_instr_d[14:12];
  assign funct7b5_d = r_instr_d[30];

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// tb_if_stage : directed bench for if_stage with a cycle-level reference model
// Rev 1.0     : initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall_f, stall_d, flush_d, pc_src_e, jalr_e;
  logic [31:0] pc_target_e, alu_result_e;
  logic [31:0] imem_addr, imem_rdata, instr_d, pc_d, pc_plus4_d, fetch_count;
  logic [6:0]  op_d;
  logic [2:0]  funct3_d;
  logic        funct7b5_d, valid_d, misalign_d;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc_d, m_pc4_d, m_cnt;
  logic        m_flag, m_valid, m_mis;

  if_stage dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .pc_src_e(pc_src_e), .jalr_e(jalr_e),
    .pc_target_e(pc_target_e), .alu_result_e(alu_result_e),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr_d(instr_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .op_d(op_d), .funct3_d(funct3_d),
    .funct7b5_d(funct7b5_d), .valid_d(valid_d), .misalign_d(misalign_d),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00A0_0093;
      32'h4:   return 32'h4020_8133;
      32'h8:   return 32'h0041_A183;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model by the fetch rules, commit after the edge.
  task automatic step(input logic rst, input logic sf, input logic sd, input logic fd,
                      input logic src, input logic jr,
                      input logic [31:0] tgt, input logic [31:0] alu);
    logic [31:0] n_pc, n_instr, n_pc_d, n_pc4_d, n_cnt, t;
    logic        n_flag, n_valid, n_mis;
    reset = rst; stall_f = sf; stall_d = sd; flush_d = fd;
    pc_src_e = src; jalr_e = jr; pc_target_e = tgt; alu_result_e = alu;
    n_pc = m_pc; n_flag = m_flag; n_instr = m_instr; n_pc_d = m_pc_d;
    n_pc4_d = m_pc4_d; n_valid = m_valid; n_mis = m_mis; n_cnt = m_cnt;
    if (rst) begin
      n_pc = 32'h0; n_flag = 1'b0; n_instr = NOP; n_pc_d = 0; n_pc4_d = 0;
      n_valid = 1'b0; n_mis = 1'b0; n_cnt = 0;
    end else begin
      if (fd) begin
        n_instr = NOP; n_pc_d = 0; n_pc4_d = 0; n_valid = 1'b0; n_mis = 1'b0;
      end else if (!sd) begin
        n_instr = mem_word(m_pc); n_pc_d = m_pc; n_pc4_d = m_pc + 4;
        n_valid = 1'b1; n_mis = m_flag; n_cnt = m_cnt + 1;
      end
      if (src) begin
        t = jr ? (alu & ~32'd1) : tgt;
        n_flag = t[1];
        n_pc = t & ~32'd3;
      end else if (!sf) begin
        n_pc = m_pc + 4;
        n_flag = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_flag = n_flag; m_instr = n_instr; m_pc_d = n_pc_d;
    m_pc4_d = n_pc4_d; m_valid = n_valid; m_mis = n_mis; m_cnt = n_cnt;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_addr",   imem_addr,   m_pc);
      chk("instr_d",     instr_d,     m_instr);
      chk("pc_d",        pc_d,        m_pc_d);
      chk("pc_plus4_d",  pc_plus4_d,  m_pc4_d);
      chk("valid_d",     {31'd0, valid_d},    {31'd0, m_valid});
      chk("misalign_d",  {31'd0, misalign_d}, {31'd0, m_mis});
      chk("fetch_count", fetch_count, m_cnt);
      chk("op_d",        {25'd0, op_d},       {25'd0, m_instr[6:0]});
      chk("funct3_d",    {29'd0, funct3_d},   {29'd0, m_instr[14:12]});
      chk("funct7b5_d",  {31'd0, funct7b5_d}, {31'd0, m_instr[30]});
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk_en = 1'b1;
    chk("rst_instr", instr_d, NOP);
    chk("rst_pc",    imem_addr, 32'h0);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);

    // free-run, then stall at pc_f=8
    idle(); idle();
    chk("pin_A1",   instr_d, 32'h4020_8133);
    chk("pin_f7b5", {31'd0, funct7b5_d}, 32'd1);
    chk("pin_pc8",  imem_addr, 32'h8);
    step(0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    step(0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    chk("stall_pc",  imem_addr, 32'h8);
    chk("stall_cnt", fetch_count, 32'd2);
    idle();
    chk("pin_A2",  instr_d, 32'h0041_A183);
    chk("pin_pcd", pc_d, 32'h8);
    chk("pin_cnt", fetch_count, 32'd3);
    chk("pin_12",  imem_addr, 32'd12);

    // branch with flush
    step(0, 0, 0, 1, 1, 0, 32'h100, 32'h0);
    chk("br_pc",    imem_addr, 32'h100);
    chk("br_instr", instr_d, 32'h0000_0013);
    chk("br_valid", {31'd0, valid_d}, 32'd0);
    idle();
    chk("br_pcd",   pc_d, 32'h100);
    chk("br_word",  instr_d, 32'hC0DE_0100);

    // jalr with bit1 set
    step(0, 0, 0, 0, 1, 1, 32'h0, 32'h203);
    chk("jalr_pc", imem_addr, 32'h200);
    idle();
    chk("mis_on",  {31'd0, misalign_d}, 32'd1);
    idle();
    chk("mis_off", {31'd0, misalign_d}, 32'd0);

    // redirect beats stall_f; flush beats stall_d; flush+stall_f holds pc
    step(0, 1, 0, 0, 1, 0, 32'h300, 32'h0);
    chk("rd_stall_pc", imem_addr, 32'h300);
    step(0, 0, 1, 1, 0, 0, 32'h0, 32'h0);
    chk("fl_sd_valid", {31'd0, valid_d}, 32'd0);
    step(0, 1, 0, 1, 0, 0, 32'h0, 32'h0);
    chk("fl_sf_pc",    imem_addr, 32'h304);

    // 32-bit wrap of the sequential PC
    step(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0);
    idle();
    chk("wrap_pc",  imem_addr, 32'h0);
    chk("wrap_pc4", pc_plus4_d, 32'h0);

    // short pseudo-random control mix
    for (int i = 0; i < 24; i++) begin
      step(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 1) == 1), $urandom & 32'h0000_0FFF,
           $urandom & 32'h0000_0FFF);
    end

    // reset during stall at 0x40, with a redirect also present
    step(0, 0, 0, 0, 1, 0, 32'h40, 32'h0);
    step(0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    chk("pre_rst_pc", imem_addr, 32'h40);
    step(1, 1, 1, 0, 1, 0, 32'h500, 32'h0);
    chk("rst2_pc",    imem_addr, 32'h0);
    chk("rst2_instr", instr_d, NOP);
    chk("rst2_cnt",   fetch_count, 32'd0);
    chk("rst2_mis",   {31'd0, misalign_d}, 32'd0);
    idle();
    chk("post_rst_A0", instr_d, 32'h00A0_0093);
    chk("post_rst_pc", pc_d, 32'h0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
